sequential_divider: RTL and testbench

Multi-cycle signed integer divider, the inverse companion of `sequential_multiplier` in the ALU's basic-module set. Accepts a WIDTH-bit signed dividend and divisor on a start strobe and runs one restoring-division step per clock. Returns a truncated-toward-zero quotient and a remainder, with a one-cycle done pulse. Used by the ALU for DIV/REM operations and by benches as a check against multiplier results.

---
 rtl/sequential_divider_if.sv | 23 ++
 rtl/sequential_divider.sv | 116 +++++++++++
 tb/tb_sequential_divider.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// Start/operand request and result bundle for the sequential divider.
interface sequential_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock on magnitudes,
// then a sign-fix step; quotient truncates toward zero, remainder follows the dividend.
module sequential_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    sequential_divider_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             sa_q;
    logic             sb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // One restoring step; the shifted partial remainder carries an extra bit so it never overflows.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        rem_d   = shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, dvs_q}) begin
            rem_d    = WIDTH'(shifted - {1'b0, dvs_q});
            quo_d[0] = 1'b1;
        end
    end

    assign a_mag   = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag   = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
    assign quo_fix = (sa_q ^ sb_q) ? (~quo_q + WIDTH'(1)) : quo_q;
    assign rem_fix = sa_q ? (~rem_q + WIDTH'(1)) : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // DONE accepts a new start exactly like IDLE for back-to-back operation.
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (bus.start) begin
                        quo_q <= a_mag;
                        dvs_q <= b_mag;
                        rem_q <= '0;
                        sa_q  <= bus.a[WIDTH-1];
                        sb_q  <= bus.b[WIDTH-1];
                        cnt_q <= '0;
                        if (bus.b != '0) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= bus.a;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient_q  <= quo_fix;
                    remainder_q <= rem_fix;
                    dbz_q       <= 1'b0;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Directed-vector and property bench for sequential_divider (WIDTH = 32).
module tb_sequential_divider;
    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sequential_divider_if #(.WIDTH(W)) bus ();

    sequential_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.a     = 'x;
        bus.b     = 'x;
    endtask

    // lat counts edges since the start was driven; -1 if done never came.
    task automatic wait_done(input int already, output int lat, output int busy_cycles);
        lat         = already;
        busy_cycles = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cycles++;
            step();
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int bc;
        issue(v.a, v.b);
        wait_done(1, lat, bc);
        check($sformatf("v%0d_latency", idx), W'(lat), W'(v.lat));
        check($sformatf("v%0d_quotient", idx), bus.quotient, v.q);
        check($sformatf("v%0d_remainder", idx), bus.remainder, v.r);
        check($sformatf("v%0d_div_by_zero", idx), W'(bus.div_by_zero), W'(v.dbz));
    endtask

    initial begin
        int lat;
        int bc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        longint sa;
        longint sb;
        longint sq;
        longint sr;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0]  = '{32'd100,             32'd7,               32'd14,              32'd2,               1'b0, 34};
        vecs[1]  = '{-32'sd100,           32'd7,               -32'sd14,            -32'sd2,             1'b0, 34};
        vecs[2]  = '{32'd100,             -32'sd7,             -32'sd14,            32'd2,               1'b0, 34};
        vecs[3]  = '{-32'sd100,           -32'sd7,             32'd14,              -32'sd2,             1'b0, 34};
        vecs[4]  = '{32'h8000_0000,       32'hFFFF_FFFF,       32'h8000_0000,       32'd0,               1'b0, 34};
        vecs[5]  = '{32'h7FFF_FFFF,       32'd1,               32'h7FFF_FFFF,       32'd0,               1'b0, 34};
        vecs[6]  = '{32'd55,              32'd0,               32'hFFFF_FFFF,       32'd55,              1'b1, 1};
        vecs[7]  = '{32'd9,               32'd3,               32'd3,               32'd0,               1'b0, 34};
        vecs[8]  = '{-32'sd7,             32'd2,               -32'sd3,             -32'sd1,             1'b0, 34};
        vecs[9]  = '{32'd0,               32'd5,               32'd0,               32'd0,               1'b0, 34};
        vecs[10] = '{32'd1,               32'h8000_0000,       32'd0,               32'd1,               1'b0, 34};
        vecs[11] = '{32'h8000_0000,       32'h8000_0000,       32'd1,               32'd0,               1'b0, 34};
        vecs[12] = '{-32'sd5,             32'd0,               32'hFFFF_FFFF,       -32'sd5,             1'b1, 1};

        step();
        step();
        rst = 1'b0;
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_quotient", bus.quotient, '0);
        check("reset_remainder", bus.remainder, '0);
        check("reset_dbz", W'(bus.div_by_zero), '0);

        // Busy width on the first plain division.
        issue(32'd100, 32'd7);
        wait_done(1, lat, bc);
        check("first_latency", W'(lat), W'(34));
        check("first_busy_cycles", W'(bc), W'(33));
        check("first_busy_at_done", W'(bus.busy), '0);
        step();
        check("done_one_pulse", W'(bus.done), '0);
        check("held_quotient", bus.quotient, 32'd14);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
            step();
        end

        // A start while busy is ignored; a start in the done cycle is accepted.
        issue(32'd1000, 32'd10);
        for (int i = 0; i < 8; i++) step();
        issue(32'd5, 32'd5);
        wait_done(10, lat, bc);
        check("ignored_latency", W'(lat), W'(34));
        check("ignored_quotient", bus.quotient, 32'd100);
        check("ignored_remainder", bus.remainder, 32'd0);
        issue(32'd5, 32'd5);
        wait_done(1, lat, bc);
        check("b2b_latency", W'(lat), W'(34));
        check("b2b_quotient", bus.quotient, 32'd1);
        check("b2b_remainder", bus.remainder, 32'd0);
        step();

        // Reset mid-calculation abandons the operation.
        issue(32'd1000, 32'd10);
        for (int i = 0; i < 14; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", W'(bus.busy), '0);
        check("midrst_done", W'(bus.done), '0);
        check("midrst_quotient", bus.quotient, '0);
        check("midrst_remainder", bus.remainder, '0);
        check("midrst_dbz", W'(bus.div_by_zero), '0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) bc++;
            step();
        end
        check("midrst_no_done", W'(bc), '0);
        issue(32'd20, 32'd3);
        wait_done(1, lat, bc);
        check("after_rst_latency", W'(lat), W'(34));
        check("after_rst_quotient", bus.quotient, 32'd6);
        check("after_rst_remainder", bus.remainder, 32'd2);
        step();

        // Random signed pairs checked against the division identity.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i % 4 == 1) rb = W'($urandom_range(1, 20));
            if (i % 4 == 2) rb = -W'($urandom_range(1, 20));
            if (rb == '0) rb = 32'd3;
            issue(ra, rb);
            wait_done(1, lat, bc);
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            sq = longint'($signed(bus.quotient));
            sr = longint'($signed(bus.remainder));
            check($sformatf("rnd%0d_latency", i), W'(lat), W'(34));
            check($sformatf("rnd%0d_identity", i), W'(sq * sb + sr), ra);
            check($sformatf("rnd%0d_rem_mag", i),
                  W'(((sr < 0) ? -sr : sr) < ((sb < 0) ? -sb : sb)), W'(1));
            check($sformatf("rnd%0d_rem_sign", i),
                  W'((sr == 0) || ((sr < 0) == (sa < 0))), W'(1));
            check($sformatf("rnd%0d_dbz", i), W'(bus.div_by_zero), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
